// File: rtl/ladybird_ram_arbiter.sv
// Two-requester arbiter in front of one in-order shared RAM port.
// Ports: req/gnt/addr/wstrb/wdata/rvalid/rdata per requester, m_* RAM side,
// err sticky on an unexpected read return. Optional LADYBIRD_RAM_ARB_RR_EN.
module ladybird_ram_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  input  logic [2*XLEN-1:0] addr,
  input  logic [7:0]        wstrb,
  input  logic [2*XLEN-1:0] wdata,
  output logic [1:0]        rvalid,
  output logic [XLEN-1:0]   rdata,
  output logic              m_req,
  input  logic              m_gnt,
  output logic [XLEN-1:0]   m_addr,
  output logic [3:0]        m_wstrb,
  output logic [XLEN-1:0]   m_wdata,
  input  logic              m_rvalid,
  input  logic [XLEN-1:0]   m_rdata,
  output logic              err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  logic [CW-1:0]              cnt;
  logic [PW-1:0]              wptr;
  logic [PW-1:0]              rptr;
  logic [MAX_OUTSTANDING-1:0] tags;

  logic [1:0] is_wr;
  logic [1:0] elig;
  logic       any;
  logic       full;
  logic       win;
  logic       push;
  logic       pop;
  logic       empty;

  assign full     = (cnt == CW'(MAX_OUTSTANDING));
  assign empty    = (cnt == '0);
  assign is_wr[0] = |wstrb[3:0];
  assign is_wr[1] = |wstrb[7:4];
  assign elig     = req & (is_wr | {2{~full}});
  assign any      = |elig;

`ifdef LADYBIRD_RAM_ARB_RR_EN
  logic pri;

  // Under contention the pointer picks; otherwise the lone eligible wins.
  assign win = (&elig) ? pri : elig[1];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pri <= 1'b0;
    end else if (|gnt) begin
      pri <= ~win;
    end
  end
`else
  assign win = ~elig[0];
`endif

  always_comb begin
    m_req   = any;
    m_addr  = '0;
    m_wstrb = '0;
    m_wdata = '0;
    gnt     = 2'b00;
    push    = 1'b0;
    if (any) begin
      m_addr  = win ? addr[2*XLEN-1:XLEN]  : addr[XLEN-1:0];
      m_wdata = win ? wdata[2*XLEN-1:XLEN] : wdata[XLEN-1:0];
      m_wstrb = win ? wstrb[7:4]           : wstrb[3:0];
      if (m_gnt) begin
        gnt  = win ? 2'b10 : 2'b01;
        push = ~is_wr[win];
      end
    end
  end

  // Read data passes straight through; rvalid steers it to the tag owner.
  assign pop    = m_rvalid & ~empty;
  assign rvalid = pop ? (tags[rptr] ? 2'b10 : 2'b01) : 2'b00;
  assign rdata  = m_rdata;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt  <= '0;
      wptr <= '0;
      rptr <= '0;
      err  <= 1'b0;
    end else begin
      if (push) begin
        tags[wptr] <= win;
        wptr       <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      cnt <= cnt + CW'(push) - CW'(pop);
      if (m_rvalid && empty) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ladybird_ram_arbiter.sv
// Self-checking bench for ladybird_ram_arbiter: directed cases plus
// randomized traffic compared every cycle against a queue-based model.
module tb_ladybird_ram_arbiter;

  localparam int XLEN = 32;
  localparam int MAXO = 4;

  logic            clk;
  logic            nrst;
  logic [1:0]      req;
  logic [1:0]      gnt;
  logic [63:0]     addr;
  logic [7:0]      wstrb;
  logic [63:0]     wdata;
  logic [1:0]      rvalid;
  logic [31:0]     rdata;
  logic            m_req;
  logic            m_gnt;
  logic [31:0]     m_addr;
  logic [3:0]      m_wstrb;
  logic [31:0]     m_wdata;
  logic            m_rvalid;
  logic [31:0]     m_rdata;
  logic            err;

  ladybird_ram_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .nrst(nrst), .req(req), .gnt(gnt), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .rvalid(rvalid), .rdata(rdata),
    .m_req(m_req), .m_gnt(m_gnt), .m_addr(m_addr), .m_wstrb(m_wstrb),
    .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: ordered list of requester ids owed read data, sticky error,
  // and the preferred requester for contended cycles.
  bit q[$];
  bit err_m = 1'b0;
  bit pri_m = 1'b0;
  bit en    = 1'b0;

  always @(negedge clk) begin : model
    bit        full;
    bit [1:0]  wr;
    bit [1:0]  el;
    bit [1:0]  eg;
    bit [1:0]  erv;
    bit        w;
    bit [31:0] ea;
    bit [31:0] ed;
    bit [3:0]  es;
    if (en) begin
      full = (q.size() >= MAXO);
      wr   = {|wstrb[7:4], |wstrb[3:0]};
      el   = req & (wr | {2{!full}});
      w    = (el == 2'b11) ? pri_m : el[1];
      eg   = (el != 2'b00 && m_gnt) ? (2'b01 << w) : 2'b00;
      ea   = 0;
      ed   = 0;
      es   = 0;
      if (el != 2'b00) begin
        ea = addr[w*32 +: 32];
        ed = wdata[w*32 +: 32];
        es = wstrb[w*4 +: 4];
      end
      erv = (m_rvalid && q.size() > 0) ? (2'b01 << q[0]) : 2'b00;
      chk("gnt", gnt, eg);
      chk("m_req", m_req, (el != 2'b00));
      chk("m_addr", m_addr, ea);
      chk("m_wdata", m_wdata, ed);
      chk("m_wstrb", m_wstrb, es);
      chk("rvalid", rvalid, erv);
      chk("rdata", rdata, m_rdata);
      chk("err", err, err_m);
      if (!nrst) begin
        q.delete();
        err_m = 1'b0;
        pri_m = 1'b0;
      end else begin
        if (m_rvalid) begin
          if (q.size() > 0) void'(q.pop_front());
          else err_m = 1'b1;
        end
        if (eg != 2'b00) begin
          if (!wr[w]) q.push_back(w);
`ifdef LADYBIRD_RAM_ARB_RR_EN
          pri_m = ~w;
`endif
        end
      end
    end
  end

  task automatic put(input logic [1:0] r, input logic [7:0] ws,
                     input logic mg, input logic mv, input logic [31:0] md);
    @(posedge clk);
    #1;
    req      = r;
    wstrb    = ws;
    m_gnt    = mg;
    m_rvalid = mv;
    m_rdata  = md;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    nrst     = 1'b0;
    req      = 2'b00;
    wstrb    = 8'h00;
    m_gnt    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = 32'h0;
    addr     = {32'h0000_0024, 32'h0000_0010};
    wdata    = {32'hBBBB_0001, 32'hAAAA_0000};
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    nrst     = 1'b0;
    req      = 2'b00;
    wstrb    = 8'h00;
    m_gnt    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = 32'h0;
    addr     = 64'h0;
    wdata    = 64'h0;
    @(posedge clk);
    #1;
    en = 1'b1;
    do_reset();

    put(2'b00, 8'h00, 1'b1, 1'b0, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_rvalid", rvalid, 2'b00);
    chk("rst_gnt", gnt, 2'b00);

    // single read, data two cycles later
    put(2'b01, 8'h00, 1'b1, 1'b0, 32'h0);
    chk("t30_gnt", gnt, 2'b01);
    chk("t30_addr", m_addr, 32'h10);
    put(2'b00, 8'h00, 1'b1, 1'b0, 32'h0);
    put(2'b00, 8'h00, 1'b1, 1'b1, 32'hDEADBEEF);
    chk("t30_rvalid", rvalid, 2'b01);
    chk("t30_rdata", rdata, 32'hDEADBEEF);

    // contention
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put(2'b11, 8'h00, 1'b1, 1'b0, 32'h0);
`ifdef LADYBIRD_RAM_ARB_RR_EN
      chk("t31_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
      chk("t31_gnt", gnt, 2'b01);
`endif
    end

    // tag FIFO full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put(2'b10, 8'h00, 1'b1, 1'b0, 32'h0);
      chk("t32_fill", gnt, 2'b10);
    end
    put(2'b10, 8'h00, 1'b1, 1'b0, 32'h0);
    chk("t32_block_gnt", gnt, 2'b00);
    chk("t32_block_mreq", m_req, 1'b0);
    put(2'b11, 8'h0F, 1'b1, 1'b0, 32'h0);
    chk("t32_wr_gnt", gnt, 2'b01);
    chk("t32_wr_strb", m_wstrb, 4'hF);
    put(2'b10, 8'h00, 1'b1, 1'b1, 32'h1234);
    chk("t32_pop_rv", rvalid, 2'b10);
    chk("t32_pop_gnt", gnt, 2'b00);
    put(2'b10, 8'h00, 1'b1, 1'b0, 32'h0);
    chk("t32_unblock", gnt, 2'b10);

    // in-order returns
    do_reset();
    put(2'b01, 8'h00, 1'b1, 1'b0, 32'h0);
    put(2'b10, 8'h00, 1'b1, 1'b0, 32'h0);
    put(2'b01, 8'h00, 1'b1, 1'b0, 32'h0);
    put(2'b00, 8'h00, 1'b0, 1'b1, 32'h11);
    chk("t33_rv0", rvalid, 2'b01);
    put(2'b00, 8'h00, 1'b0, 1'b1, 32'h22);
    chk("t33_rv1", rvalid, 2'b10);
    put(2'b00, 8'h00, 1'b0, 1'b1, 32'h33);
    chk("t33_rv2", rvalid, 2'b01);

    // spurious return
    do_reset();
    put(2'b00, 8'h00, 1'b0, 1'b1, 32'h55);
    chk("t34_rv", rvalid, 2'b00);
    put(2'b00, 8'h00, 1'b0, 1'b0, 32'h0);
    chk("t34_err", err, 1'b1);
    put(2'b00, 8'h00, 1'b0, 1'b0, 32'h0);
    chk("t34_hold", err, 1'b1);
    do_reset();
    put(2'b00, 8'h00, 1'b0, 1'b0, 32'h0);
    chk("t34_clr", err, 1'b0);

    // RAM stalls
    put(2'b11, 8'h00, 1'b0, 1'b0, 32'h0);
    chk("t35_gnt", gnt, 2'b00);
    chk("t35_mreq", m_req, 1'b1);
    put(2'b00, 8'h00, 1'b0, 1'b1, 32'h66);
    chk("t35_nopush", rvalid, 2'b00);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      nrst  = ($urandom_range(399) != 0);
      req   = 2'($urandom);
      addr  = {$urandom, $urandom};
      wdata = {$urandom, $urandom};
      for (int k = 0; k < 2; k++)
        wstrb[k*4 +: 4] = $urandom_range(1) ? 4'h0 : 4'($urandom_range(15, 1));
      m_gnt    = ($urandom_range(3) != 0);
      m_rdata  = $urandom;
      m_rvalid = (q.size() > 0) ? ($urandom_range(4) < 2)
                                : ($urandom_range(249) == 0);
    end
    @(posedge clk);
    #1;
    en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
